// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two one-entry holding buffers (ALU, load) share the register-file write port.
// Optional feature: define RF_WB_R0_ZERO_EN to drop writes to register 0.
module rf_wb_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_rd,
  input  logic [DW-1:0]        a_data,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [AW-1:0]        m_rd,
  input  logic [DW-1:0]        m_data,
  output logic [AW-1:0]        Rd,
  output logic [DW-1:0]        RW,
  output logic                 wr,
  output logic [(1<<AW)-1:0]   wb_pending
);

  logic          full_a, full_m;
  logic [AW-1:0] rd_a, rd_m;
  logic [DW-1:0] data_a, data_m;
  logic          rr;   // round-robin pointer: 0 = A next, 1 = M next
  logic          age;  // 0 = A older, 1 = M older (meaningful when both full)
  logic          grant_a, grant_m;
  logic          accept_a, accept_m;
  logic          store_a, store_m;

  // Arbitration looks only at buffer contents; same-rd pairs retire oldest first.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (full_a && full_m) begin
      if (rd_a == rd_m) begin
        grant_a = !age;
        grant_m = age;
      end else begin
        grant_a = !rr;
        grant_m = rr;
      end
    end else begin
      grant_a = full_a;
      grant_m = full_m;
    end
  end

  assign a_ready  = !rst && (!full_a || grant_a);
  assign m_ready  = !rst && (!full_m || grant_m);
  assign accept_a = a_valid && a_ready;
  assign accept_m = m_valid && m_ready;

`ifdef RF_WB_R0_ZERO_EN
  // Register 0 is hard-wired: the handshake completes but nothing is buffered.
  assign store_a = accept_a && (a_rd != '0);
  assign store_m = accept_m && (m_rd != '0);
`else
  assign store_a = accept_a;
  assign store_m = accept_m;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      full_a <= 1'b0;
      full_m <= 1'b0;
      rd_a   <= '0;
      rd_m   <= '0;
      data_a <= '0;
      data_m <= '0;
      rr     <= 1'b0;
      age    <= 1'b0;
      wr     <= 1'b0;
      Rd     <= '0;
      RW     <= '0;
    end else begin
      if (store_a) begin
        full_a <= 1'b1;
        rd_a   <= a_rd;
        data_a <= a_data;
      end else if (grant_a) begin
        full_a <= 1'b0;
      end
      if (store_m) begin
        full_m <= 1'b1;
        rd_m   <= m_rd;
        data_m <= m_data;
      end else if (grant_m) begin
        full_m <= 1'b0;
      end
      if (full_a && full_m && (rd_a != rd_m))
        rr <= grant_a;
      // The side loaded alone becomes the younger one.
      if (store_a && store_m)
        age <= 1'b0;
      else if (store_a)
        age <= 1'b1;
      else if (store_m)
        age <= 1'b0;
      wr <= grant_a || grant_m;
      if (grant_a) begin
        Rd <= rd_a;
        RW <= data_a;
      end else if (grant_m) begin
        Rd <= rd_m;
        RW <= data_m;
      end
    end
  end

  for (genvar gi = 0; gi < (1 << AW); gi++) begin : g_pending
    assign wb_pending[gi] = (full_a && (rd_a == AW'(gi))) ||
                            (full_m && (rd_m == AW'(gi))) ||
                            (wr     && (Rd   == AW'(gi)));
  end

endmodule
